fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 131 +++++++++++++
 tb/tb_fetch_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch front end. A registered PC drives the instruction port of
// Memory directly; the word that comes back in the same cycle is pushed,
// together with its address, into a 2-entry queue that decode drains through a
// valid/ready handshake. The execute stage can redirect the PC, which flushes
// the queue.
//
// Handshake: the head entry transfers to decode on a rising edge where
// inst_valid = 1 and inst_ready = 1. inst_valid never depends on inst_ready,
// and inst/inst_pc hold their value while inst_valid = 1 and inst_ready = 0.
//
// Ports
//   clk            in   1   clock, all state updates on the rising edge
//   rst            in   1   asynchronous active-high reset
//   a_m1           out  32  instruction address (registered PC)
//   d_m1           in   32  instruction word for a_m1, same cycle
//   halt           in   1   stop fetching; queued entries still drain
//   branch_taken   in   1   redirect request (wins over halt)
//   branch_pc      in   32  redirect target
//   inst_valid     out  1   queue head is valid
//   inst_ready     in   1   decode accepts the head this cycle
//   inst           out  32  instruction word at queue head
//   inst_pc        out  32  address inst was fetched from
//   misaligned_err out  1   sticky: a redirect target had branch_pc[1:0] != 0
//                           (only built when FETCH_ALIGN_CHECK_EN is defined)
//
// Configuration macro: FETCH_ALIGN_CHECK_EN enables the redirect alignment
// check and the misaligned_err port.
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] a_m1,
  input  logic [31:0] d_m1,
  input  logic        halt,
  input  logic        branch_taken,
  input  logic [31:0] branch_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        misaligned_err
`endif
);

  logic [31:0] pc;
  logic [1:0]  count;
  // The head entry lives directly in the inst/inst_pc output registers; the
  // second entry sits behind it and shifts forward on a pop.
  logic [31:0] tail_inst;
  logic [31:0] tail_pc;
  logic        push;
  logic        pop;

  assign a_m1       = pc;
  assign inst_valid = (count != 2'd0);

  // A push is decided on the occupancy before any pop of the same cycle, so a
  // full queue never accepts a new word even while it is being drained.
  always_comb begin
    push = 1'b0;
    pop  = 1'b0;
    push = !branch_taken && !halt && (count != 2'd2);
    pop  = inst_valid && inst_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      count     <= 2'd0;
      inst      <= 32'h0;
      inst_pc   <= 32'h0;
      tail_inst <= 32'h0;
      tail_pc   <= 32'h0;
    end else if (branch_taken) begin
      // Flush discards any pop handshake of this cycle as well.
      count <= 2'd0;
      pc    <= branch_pc;
    end else begin
      if (push) begin
        pc <= pc + 32'd4;
      end
      case (count)
        2'd0: begin
          if (push) begin
            inst    <= d_m1;
            inst_pc <= pc;
            count   <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            inst    <= d_m1;
            inst_pc <= pc;
          end else if (push) begin
            tail_inst <= d_m1;
            tail_pc   <= pc;
            count     <= 2'd2;
          end else if (pop) begin
            count <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            inst    <= tail_inst;
            inst_pc <= tail_pc;
            count   <= 2'd1;
          end
        end
        default: count <= 2'd0;
      endcase
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misaligned_err <= 1'b0;
    end else if (branch_taken && (branch_pc[1:0] != 2'b00)) begin
      misaligned_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed and random stimulus for fetch_unit. The reference is a queue of
// {instruction, pc} pairs plus a PC variable, advanced once per clock from the
// behavioural rules of the fetch unit. Memory is modelled as a fixed hash of
// the address so every fetched word is predictable.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic [31:0] a_m1;
  logic [31:0] d_m1;
  logic        halt;
  logic        branch_taken;
  logic [31:0] branch_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        misaligned_err;
`endif

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .a_m1         (a_m1),
    .d_m1         (d_m1),
    .halt         (halt),
    .branch_taken (branch_taken),
    .branch_pc    (branch_pc),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .inst         (inst),
    .inst_pc      (inst_pc)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .misaligned_err (misaligned_err)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign d_m1 = mem_word(a_m1);

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] exp_q[$];      // expected instruction words, head first
  logic [31:0] exp_pc_q[$];   // matching fetch addresses
  logic [31:0] m_pc;
  logic        m_err;
  int          checks;
  int          errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_pc_q.delete();
    m_pc  = RESET_PC;
    m_err = 1'b0;
  endtask

  // One clock of the reference, using the inputs that were applied this cycle.
  task automatic model_step(input logic h, input logic br, input logic [31:0] bpc,
                            input logic rdy);
    bit do_push;
    bit do_pop;
    if (br) begin
      exp_q.delete();
      exp_pc_q.delete();
      m_pc = bpc;
      if (bpc[1:0] != 2'b00) m_err = 1'b1;
    end else begin
      do_push = !h && (exp_q.size() < 2);
      do_pop  = (exp_q.size() > 0) && rdy;
      if (do_pop) begin
        void'(exp_q.pop_front());
        void'(exp_pc_q.pop_front());
      end
      if (do_push) begin
        exp_q.push_back(mem_word(m_pc));
        exp_pc_q.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".a_m1"}, a_m1, m_pc);
    chk({tag, ".valid"}, {31'd0, inst_valid}, {31'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      chk({tag, ".inst"}, inst, exp_q[0]);
      chk({tag, ".inst_pc"}, inst_pc, exp_pc_q[0]);
    end
`ifdef FETCH_ALIGN_CHECK_EN
    chk({tag, ".merr"}, {31'd0, misaligned_err}, {31'd0, m_err});
`endif
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge: apply inputs, check the outputs the
  // model predicts for this cycle, then advance DUT and model on the rising edge.
  task automatic cycle(input string tag, input logic h, input logic br,
                       input logic [31:0] bpc, input logic rdy);
    halt         = h;
    branch_taken = br;
    branch_pc    = bpc;
    inst_ready   = rdy;
    #1;
    check_outputs(tag);
    @(posedge clk);
    model_step(h, br, bpc, rdy);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    halt         = 1'b0;
    branch_taken = 1'b0;
    branch_pc    = 32'h0;
    inst_ready   = 1'b0;
    model_reset();

    // Reset values while rst is held.
    #2;
    chk("rst.a_m1", a_m1, RESET_PC);
    chk("rst.valid", {31'd0, inst_valid}, 32'd0);
    chk("rst.inst", inst, 32'h0);
    chk("rst.inst_pc", inst_pc, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("rst.merr", {31'd0, misaligned_err}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Streaming with decode always ready: a_m1 steps by 4, inst_pc trails.
    for (int i = 0; i < 6; i++) cycle("stream", 1'b0, 1'b0, 32'h0, 1'b1);
    chk("stream.a_m1_const", a_m1, RESET_PC + 32'd24);

    // Back-pressure from a fresh reset: queue saturates, a_m1 holds at 8.
    rst = 1'b1;
    #1;
    model_reset();
    chk("midrst.valid", {31'd0, inst_valid}, 32'd0);
    chk("midrst.a_m1", a_m1, RESET_PC);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) cycle("stall", 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    chk("stall.a_m1_const", a_m1, RESET_PC + 32'd8);
    chk("stall.inst_pc_const", inst_pc, RESET_PC);

    // Redirect while full: flush, fetch from 0x100, valid two edges later.
    cycle("br100", 1'b0, 1'b1, 32'h0000_0100, 1'b1);
    #1;
    chk("br100.valid_flushed", {31'd0, inst_valid}, 32'd0);
    chk("br100.a_m1_const", a_m1, 32'h0000_0100);
    cycle("br100.fetch", 1'b0, 1'b0, 32'h0, 1'b1);
    #1;
    chk("br100.inst_pc_const", inst_pc, 32'h0000_0100);

    // Fill the queue, then halt and drain it; then redirect while halted.
    cycle("fill", 1'b0, 1'b0, 32'h0, 1'b0);
    cycle("fill", 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) cycle("halt", 1'b1, 1'b0, 32'h0, 1'b1);
    #1;
    chk("halt.valid_const", {31'd0, inst_valid}, 32'd0);
    cycle("halt.br", 1'b1, 1'b1, 32'h0000_0200, 1'b1);
    cycle("halt.after", 1'b1, 1'b0, 32'h0, 1'b1);
    #1;
    chk("halt.br_a_m1_const", a_m1, 32'h0000_0200);

    // PC wrap-around at the top of the address space.
    cycle("wrap.br", 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    cycle("wrap", 1'b0, 1'b0, 32'h0, 1'b1);
    #1;
    chk("wrap.a_m1_const", a_m1, 32'h0000_0000);
    chk("wrap.inst_pc_const", inst_pc, 32'hFFFF_FFFC);
    cycle("wrap", 1'b0, 1'b0, 32'h0, 1'b1);

`ifdef FETCH_ALIGN_CHECK_EN
    // Misaligned redirect: still taken, error sticks until reset.
    cycle("mis.br", 1'b0, 1'b1, 32'h0000_0102, 1'b1);
    for (int i = 0; i < 3; i++) cycle("mis", 1'b0, 1'b0, 32'h0, 1'b1);
    #1;
    chk("mis.merr_const", {31'd0, misaligned_err}, 32'd1);
`endif

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic        r_h;
      logic        r_br;
      logic [31:0] r_bpc;
      logic        r_rdy;
      r_h   = ($urandom_range(0, 5) == 0);
      r_br  = ($urandom_range(0, 11) == 0);
      r_bpc = $urandom;
`ifndef FETCH_ALIGN_CHECK_EN
      r_bpc[1:0] = 2'b00;
`endif
      if ($urandom_range(0, 3) == 0) r_bpc[1:0] = 2'b00;
      r_rdy = ($urandom_range(0, 2) != 0);
      cycle("rand", r_h, r_br, r_bpc, r_rdy);
    end

    // Asynchronous reset mid-operation clears everything before any edge.
    cycle("pre_rst", 1'b0, 1'b0, 32'h0, 1'b0);
    branch_taken = 1'b1;
    branch_pc    = 32'h0000_0400;
    rst          = 1'b1;
    #1;
    model_reset();
    chk("arst.a_m1", a_m1, RESET_PC);
    chk("arst.valid", {31'd0, inst_valid}, 32'd0);
    chk("arst.inst", inst, 32'h0);
    chk("arst.inst_pc", inst_pc, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("arst.merr", {31'd0, misaligned_err}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cycle("post_rst", 1'b0, 1'b0, 32'h0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
